// File: rtl/input_channel_buffer.sv
// Per-channel input FIFO for the TIA datapath. Holds tagged words from the
// interconnect and presents the oldest entry to trigger resolution and the
// operand muxes. The head is a combinational read of storage, so a word
// written at one edge is visible right after that edge. Ready and head
// outputs depend only on registered state, never on enqueue_valid or dequeue.
module input_channel_buffer #(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enqueue_valid,
    output logic                         enqueue_ready,
    input  logic [TAG_WIDTH-1:0]         enqueue_tag,
    input  logic [DATA_WIDTH-1:0]        enqueue_data,
    input  logic                         dequeue,
    output logic                         head_valid,
    output logic [TAG_WIDTH-1:0]         head_tag,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         underflow_error
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake and status are pure functions of the registered count.
    always_comb begin
        enqueue_ready = (count != FULL_CNT);
        head_valid    = (count != '0);
        occupancy     = count;
        push          = enqueue_valid && enqueue_ready;
        pop           = dequeue && head_valid;
    end

    // Head is read straight out of storage and forced to zero while empty,
    // so stale entries never leak out after a pop or a reset.
    always_comb begin
        head_entry = storage[rd_ptr];
        if (count == '0) begin
            head_tag  = '0;
            head_data = '0;
        end else begin
            head_tag  = head_entry[ENTRY_W-1:DATA_WIDTH];
            head_data = head_entry[DATA_WIDTH-1:0];
        end
    end

    // Storage array is deliberately left out of reset; the masked head and
    // the cleared count make its contents irrelevant until rewritten.
    always_ff @(posedge clock) begin
        if (push) begin
            storage[wr_ptr] <= {enqueue_tag, enqueue_data};
        end
    end

    // Pointers, count and the sticky underflow flag; reset drops all entries
    // immediately without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            underflow_error <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (dequeue && !head_valid) begin
                underflow_error <= 1'b1;
            end
        end
    end

endmodule
